// File: rtl/bottle_count_scan_pkg.sv
// Shared constants and BCD helper for the bottle counter / display scanner.
package bottle_count_scan_pkg;

    localparam logic [1:0] DIG_BOT_ONES = 2'd0;
    localparam logic [1:0] DIG_BOT_TENS = 2'd1;
    localparam logic [1:0] DIG_BOX_ONES = 2'd2;
    localparam logic [1:0] DIG_BOX_TENS = 2'd3;

    localparam logic [3:0] DIG_EN_RST = 4'b1110;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // Two-digit BCD increment; bit 8 is the carry out of 99 -> 00.
    function automatic logic [8:0] bcd2_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        logic       c;
        lo = v[3:0];
        hi = v[7:4];
        c  = 1'b0;
        if (lo == BCD_MAX) begin
            lo = 4'd0;
            if (hi == BCD_MAX) begin
                hi = 4'd0;
                c  = 1'b1;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {c, hi, lo};
    endfunction

endpackage

// File: rtl/bottle_count_scan_sensor_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for the bottle sensor.
module bottle_count_scan_sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_i,
    output logic db_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s_sync;

    assign s_sync = sync_q[1];
    assign db_o   = db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], sensor_i};
            if (s_sync == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This is the last of the required consecutive disagreeing samples.
                db_q  <= s_sync;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bottle_count_scan.sv
// Bottle/box BCD counter with a 4-digit multiplexed BCD display scanner.
// Optional build macro BLANK_LEADING_ZERO_EN darkens zero tens digits.
module bottle_count_scan
    import bottle_count_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BOX_SIZE        = 12,
    parameter int SCAN_DIV        = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic       enable,
    input  logic       clear,
    output logic [7:0] bottles_bcd,
    output logic [7:0] boxes_bcd,
    output logic       box_full,
    output logic       box_ovf,
    output logic [3:0] bcd,
    output logic [3:0] dig_en_n
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       BOX_LAST = {4'((BOX_SIZE - 1) / 10), 4'((BOX_SIZE - 1) % 10)};

    logic             db;
    logic             db_prev_q;
    logic             enable_q;
    logic             evt;
    logic [7:0]       bottles_q, bottles_d;
    logic [7:0]       boxes_q, boxes_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [8:0]       bot_inc, box_inc;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       bcd_q, bcd_d;
    logic [3:0]       en_q, en_d;
    logic             adv;

    bottle_count_scan_sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sensor_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .sensor_i(sensor),
        .db_o    (db)
    );

    // enable_q is enable as sampled on the edge where db rose.
    assign evt     = db & ~db_prev_q & enable_q;
    assign bot_inc = bcd2_inc(bottles_q);
    assign box_inc = bcd2_inc(boxes_q);

    always_comb begin
        bottles_d = bottles_q;
        boxes_d   = boxes_q;
        ovf_d     = ovf_q;
        full_d    = 1'b0;
        if (clear) begin
            bottles_d = 8'h00;
            boxes_d   = 8'h00;
            ovf_d     = 1'b0;
        end else if (evt) begin
            if (bottles_q == BOX_LAST) begin
                bottles_d = 8'h00;
                boxes_d   = box_inc[7:0];
                full_d    = 1'b1;
                if (box_inc[8]) ovf_d = 1'b1;
            end else begin
                bottles_d = bot_inc[7:0];
            end
        end
    end

    always_comb begin
        adv   = (div_q == DIV_LAST);
        div_d = adv ? '0 : div_q + DIV_W'(1);
        idx_d = adv ? idx_q + 2'd1 : idx_q;
        bcd_d = bcd_q;
        en_d  = en_q;
        if (adv) begin
            case (idx_d)
                DIG_BOT_ONES: bcd_d = bottles_q[3:0];
                DIG_BOT_TENS: bcd_d = bottles_q[7:4];
                DIG_BOX_ONES: bcd_d = boxes_q[3:0];
                default:      bcd_d = boxes_q[7:4];
            endcase
            en_d = ~(4'b0001 << idx_d);
`ifdef BLANK_LEADING_ZERO_EN
            if ((idx_d == DIG_BOT_TENS && bottles_q[7:4] == 4'd0) ||
                (idx_d == DIG_BOX_TENS && boxes_q[7:4] == 4'd0))
                en_d = 4'b1111;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_q <= 1'b0;
            enable_q  <= 1'b0;
            bottles_q <= 8'h00;
            boxes_q   <= 8'h00;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            div_q     <= '0;
            idx_q     <= DIG_BOT_ONES;
            bcd_q     <= 4'h0;
            en_q      <= DIG_EN_RST;
        end else begin
            db_prev_q <= db;
            enable_q  <= enable;
            bottles_q <= bottles_d;
            boxes_q   <= boxes_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
        end
    end

    assign bottles_bcd = bottles_q;
    assign boxes_bcd   = boxes_q;
    assign box_full    = full_q;
    assign box_ovf     = ovf_q;
    assign bcd         = bcd_q;
    assign dig_en_n    = en_q;

endmodule

// File: tb/tb_bottle_count_scan.sv
// Randomized bench for bottle_count_scan against a count-of-events reference model.
module tb_bottle_count_scan;

    localparam int DB = 4;
    localparam int BS = 12;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] bottles_bcd, boxes_bcd;
    logic       box_full, box_ovf;
    logic [3:0] bcd, dig_en_n;

    int n_chk  = 0;
    int n_pass = 0;
    int n_evt  = 0;  // qualified bottle events since reset or clear

    bottle_count_scan #(
        .DEBOUNCE_CYCLES(DB),
        .BOX_SIZE       (BS),
        .SCAN_DIV       (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor     (sensor),
        .enable     (enable),
        .clear      (clear),
        .bottles_bcd(bottles_bcd),
        .boxes_bcd  (boxes_bcd),
        .box_full   (box_full),
        .box_ovf    (box_ovf),
        .bcd        (bcd),
        .dig_en_n   (dig_en_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int m_bot();
        return n_evt % BS;
    endfunction

    function automatic int m_box();
        return (n_evt / BS) % 100;
    endfunction

    function automatic logic m_ovf();
        return (n_evt / BS) >= 100;
    endfunction

    function automatic logic [3:0] m_digit(input int i);
        case (i)
            0:       return 4'(m_bot() % 10);
            1:       return 4'(m_bot() / 10);
            2:       return 4'(m_box() % 10);
            default: return 4'(m_box() / 10);
        endcase
    endfunction

    function automatic logic [3:0] m_en(input int i);
        logic [3:0] e;
        e    = 4'b1111;
        e[i] = 1'b0;
`ifdef BLANK_LEADING_ZERO_EN
        if ((i == 1 || i == 3) && m_digit(i) == 4'd0) e = 4'b1111;
`endif
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_bottles"}, bottles_bcd, 8'h00);
        check({tag, "_boxes"}, boxes_bcd, 8'h00);
        check({tag, "_full"}, box_full, 1'b0);
        check({tag, "_ovf"}, box_ovf, 1'b0);
        check({tag, "_bcd"}, bcd, 4'h0);
        check({tag, "_en"}, dig_en_n, 4'b1110);
    endtask

    // Sensor high for h cycles then low for l; checks the update edge exactly.
    task automatic pulse(input int h, input int l, input bit en, input bit clr);
        bit counts;
        bit full;
        counts = (h >= DB) && en;
        @(negedge clk);
        enable = en;
        sensor = 1'b1;
        for (int c = 0; c < h + l; c++) begin
            @(posedge clk);
            #1;
            if (c == DB + 1) check("pre_update", bottles_bcd, to_bcd(m_bot()));
            if (c == DB + 2) begin
                full = 1'b0;
                if (clr) n_evt = 0;
                else if (counts) begin
                    n_evt++;
                    full = (n_evt % BS == 0);
                end
                check("bottles", bottles_bcd, to_bcd(m_bot()));
                check("boxes", boxes_bcd, to_bcd(m_box()));
                check("box_full", box_full, full);
                check("box_ovf", box_ovf, m_ovf());
            end
            if (c == DB + 3) check("box_full_end", box_full, 1'b0);
            @(negedge clk);
            sensor = (c + 1 < h);
            clear  = clr && (c == DB + 1);
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        int r;
        guard = 0;
        while (n_evt < target && guard < 5000) begin
            guard++;
            r = $urandom_range(0, 99);
            if (r < 75)      pulse($urandom_range(DB, DB + 3), $urandom_range(DB + 3, DB + 5), 1'b1, 1'b0);
            else if (r < 88) pulse($urandom_range(DB, DB + 3), $urandom_range(DB + 3, DB + 5), 1'b0, 1'b0);
            else             pulse($urandom_range(1, DB - 1), $urandom_range(DB + 3, DB + 5), 1'b1, 1'b0);
        end
        if (n_evt != target) check("run_to_budget", n_evt, target);
    endtask

    task automatic scan_check();
        logic [3:0] prev;
        bit         found;
        int         w;
        w     = 0;
        found = 1'b0;
        @(posedge clk);
        #1;
        prev = dig_en_n;
        while (!found && w < 4 * SD + 4) begin
            @(posedge clk);
            #1;
            w++;
            found = (dig_en_n == 4'b1110) && (prev != 4'b1110);
            prev  = dig_en_n;
        end
        check("scan_sync", found, 1'b1);
        for (int s = 0; s < 4 * SD; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            check("scan_en", dig_en_n, m_en(s / SD));
            check("scan_bcd", bcd, m_digit(s / SD));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= SD; e++) begin
            @(posedge clk);
            #1;
            if (e == SD - 1) check("scan_pre_adv", dig_en_n, 4'b1110);
            if (e == SD) begin
                check("scan_first_adv_en", dig_en_n, m_en(1));
                check("scan_first_adv_bcd", bcd, m_digit(1));
            end
        end

        for (int i = 0; i < 3; i++) pulse(DB + 1, DB + 4, 1'b1, 1'b0);
        check("three_pulses", bottles_bcd, 8'h03);
        pulse(DB - 1, DB + 4, 1'b1, 1'b0);
        check("glitch_ignored", bottles_bcd, 8'h03);

        run_to(42 * BS + 7);
        scan_check();

        run_to(99 * BS + 11);
        check("pre_wrap_ovf", box_ovf, 1'b0);
        pulse(DB, DB + 4, 1'b1, 1'b0);
        check("wrap_boxes", boxes_bcd, 8'h00);
        check("wrap_ovf", box_ovf, 1'b1);
        pulse(DB + 2, DB + 4, 1'b1, 1'b0);
        pulse(DB + 1, DB + 3, 1'b1, 1'b0);
        check("ovf_sticky", box_ovf, 1'b1);
        pulse(DB + 1, DB + 4, 1'b1, 1'b1);
        check("clear_wins_ovf", box_ovf, 1'b0);
        pulse(DB + 1, DB + 4, 1'b1, 1'b0);
        check("after_clear", bottles_bcd, 8'h01);

        // Asynchronous reset in the middle of a pulse, between clock edges.
        @(negedge clk);
        enable = 1'b1;
        sensor = 1'b1;
        repeat (DB + 1) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        n_evt  = 0;
        sensor = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DB + 4) @(posedge clk);
        pulse(DB + 2, DB + 4, 1'b1, 1'b0);
        check("post_reset_count", bottles_bcd, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
